alu_muldiv_seq: RTL
===================

Name: alu_muldiv_seq

Overview:
- Iterative 16-bit unsigned multiply/divide sequencer that drives an external combinational 74181-style ALU from the other side of its interface: it supplies select, mode and operands, and consumes the result and carry-out.
- Uses only the ALU add function, one ALU evaluation per cycle, for shift-add multiply and restoring divide.
- Sits between the datapath issue stage and the shared ALU.
- Operand and result handshakes are valid/ready.

Parameters:
WIDTH, 16, operand width; must match ALU width.
ADD_SEL, 4'b1001, ALU select code giving y = a + b, co = carry-out.
ADD_M, 1'b0, ALU mode bit for arithmetic.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operation request.
in_ready  output  1  high only in IDLE.
in_op  input  1  0 = MUL, 1 = DIVU.
in_a  input  WIDTH  multiplicand / dividend.
in_b  input  WIDTH  multiplier / divisor.
res_valid  output  1  result available.
res_ready  input  1  result consumed.
res_hi  output  WIDTH  MUL: product[31:16]; DIVU: remainder.
res_lo  output  WIDTH  MUL: product[15:0]; DIVU: quotient.
res_dz  output  1  divide-by-zero flag.
alu_s  output  4 ([0:3])  constant ADD_SEL.
alu_m  output  1  constant ADD_M.
alu_a  output  WIDTH  ALU operand A.
alu_b  output  WIDTH  ALU operand B.
alu_y  input  WIDTH  ALU result, sampled in the same cycle.
alu_co  input  1  ALU carry-out, sampled in the same cycle.

Behaviour:
- Reset (async assert, sync release): state = IDLE; in_ready = 1; res_valid, res_dz = 0; res_hi, res_lo, alu_a, alu_b = 0.
- States: IDLE, PREP, ITER, DONE. A 5-bit counter cnt counts ITER cycles 0..15.
- IDLE: when in_valid & in_ready, latch op and operands.
  - MUL → ITER.
  - DIVU, in_b != 0 → PREP.
  - DIVU, in_b == 0 → DONE with res_dz = 1, res_lo = 16'hFFFF, res_hi = in_a. No ALU use.
- PREP (DIVU only, 1 cycle): alu_a = ~divisor, alu_b = 1; register negd = alu_y.
- ITER, MUL: acc = 0 at entry.
  - alu_a = acc; alu_b = mplier[0] ? mcand : 0.
  - Update {acc, mplier} <= {alu_co, alu_y, mplier} >> 1.
- ITER, DIVU: r = 0 at entry; sh = {r, dvd[15]} (17 bits).
  - alu_a = sh[15:0]; alu_b = negd.
  - ge = alu_co | sh[16].
  - r <= ge ? alu_y : sh[15:0]; dvd <= {dvd[14:0], ge}. dvd becomes the quotient.
- ITER exits after cnt == 15 → DONE.
- Outside PREP/ITER, alu_a and alu_b hold 0.
- Latency from the acceptance edge to res_valid high: MUL 17 cycles, DIVU 18 cycles, divide-by-zero 1 cycle.
- DONE: res_valid = 1; res_* registered and held stable until res_valid & res_ready, then → IDLE.
  - No new request is accepted in the same cycle as the result handshake. Next acceptance is possible one cycle later.
- in_valid is ignored outside IDLE. in_a, in_b and in_op are only sampled at acceptance.
- Reset asserted mid-operation aborts immediately to the reset values. The partial result is discarded.

Optional Feature:
MULDIV_EARLY_EXIT_EN
- Defined: in MUL ITER, when the remaining unshifted multiplier bits are all zero, the block finishes the product as a single shift of {acc, mplier} by the remaining count and enters DONE next cycle.
  - Minimum MUL latency is 2 cycles (multiplier 0).
  - Result is bit-identical to the non-early-exit result.
- Undefined: fixed 17-cycle MUL latency. DIVU is unaffected in both cases.

Decomposition:
- Shared package: opcode enum (MUL, DIVU), state enum, ADD_SEL/ADD_M defaults, WIDTH constant.
- One natural sub-module: alu_muldiv_step, the combinational per-iteration next-state for acc/r, mplier/dvd and ge, instantiated once.
- Top module holds the FSM, counter and handshakes.

Test Plan:
- MUL 16'hFFFF × 16'hFFFF, res_ready = 1 → res_hi = 16'hFFFE, res_lo = 16'h0001, res_dz = 0, res_valid exactly 17 cycles after acceptance (macro off).
- DIVU 16'h1234 / 16'h0010 → res_lo = 16'h0123, res_hi = 16'h0004, res_valid 18 cycles after acceptance. alu_a = 16'hFFEF, alu_b = 1 in PREP.
- DIVU 16'hFFFF / 16'h8001 (exercises the 17-bit shifted remainder) → res_lo = 16'h0001, res_hi = 16'h7FFE.
- DIVU 16'h5A5A / 0 → res_dz = 1, res_lo = 16'hFFFF, res_hi = 16'h5A5A, 1-cycle latency, alu_a/alu_b stay 0.
- MUL 3 × 5 with res_ready low for 5 cycles → res_hi:res_lo = 0:16'h000F held stable, in_ready = 0 throughout. After the handshake, in_ready = 1 the next cycle and back-to-back DIVU 7/2 → quotient 3, remainder 1. With MULDIV_EARLY_EXIT_EN, the 3 × 5 MUL completes in fewer than 17 cycles with the same result.
- rst_n pulsed low at ITER cnt = 8 of a MUL → all outputs return to reset values asynchronously. After release, in_ready = 1 and a fresh MUL 2 × 2 yields 0:16'h0004.

Source files
------------

// File: rtl/alu_muldiv_seq_pkg.sv
// Shared types and defaults for the iterative multiply/divide sequencer.
// Holds the opcode and FSM state enums plus the ALU add-select defaults.
package alu_muldiv_seq_pkg;

    localparam int         MD_WIDTH   = 16;
    localparam logic [3:0] MD_ADD_SEL = 4'b1001;
    localparam logic       MD_ADD_M   = 1'b0;

    typedef enum logic {
        OP_MUL  = 1'b0,
        OP_DIVU = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_DONE
    } state_e;

endpackage

// File: rtl/alu_muldiv_step.sv
// Combinational per-iteration step for shift-add MUL and restoring DIVU.
// Ports: op, hi (acc/r), lo (mplier/dvd), opb (mcand/negd), alu_y/alu_co
// in; alu_a/alu_b operands and hi_n/lo_n next state out. With
// MULDIV_EARLY_EXIT_EN: cnt in, early out (MUL remaining bits all zero).
module alu_muldiv_step
    import alu_muldiv_seq_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             op,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] opb,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_co,
`ifdef MULDIV_EARLY_EXIT_EN
    input  logic [4:0]       cnt,
    output logic             early,
`endif
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [WIDTH-1:0] hi_n,
    output logic [WIDTH-1:0] lo_n
);

    // Remainder shifted left by one with the next dividend bit; the top
    // bit is the 17th bit that forces "remainder >= divisor".
    logic [WIDTH:0] sh;
    logic           ge;

`ifdef MULDIV_EARLY_EXIT_EN
    logic [WIDTH-1:0]   rem_mask;
    logic [6:0]         shamt;
    logic [2*WIDTH-1:0] cat_sh;
`endif

    always_comb begin
        sh = {hi, lo[WIDTH-1]};
        ge = alu_co | sh[WIDTH];
        if (op == OP_MUL) begin
            alu_a = hi;
            alu_b = lo[0] ? opb : '0;
            hi_n  = {alu_co, alu_y[WIDTH-1:1]};
            lo_n  = {alu_y[0], lo[WIDTH-1:1]};
        end else begin
            alu_a = sh[WIDTH-1:0];
            alu_b = opb;
            hi_n  = ge ? alu_y : sh[WIDTH-1:0];
            lo_n  = {lo[WIDTH-2:0], ge};
        end
`ifdef MULDIV_EARLY_EXIT_EN
        // The low WIDTH-cnt bits of lo are still unconsumed multiplier
        // bits; once they are zero every remaining step is a pure shift.
        rem_mask = {WIDTH{1'b1}} >> cnt;
        shamt    = 7'(WIDTH) - {2'b00, cnt};
        cat_sh   = {hi, lo} >> shamt;
        early    = (op == OP_MUL) && ((lo & rem_mask) == '0);
        if (early) begin
            hi_n = cat_sh[2*WIDTH-1:WIDTH];
            lo_n = cat_sh[WIDTH-1:0];
        end
`endif
    end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned MUL/DIVU sequencer driving an external 74181-style ALU.
// Ports: clk, rst_n; in_valid/in_ready/in_op/in_a/in_b request;
// res_valid/res_ready/res_hi/res_lo/res_dz result; alu_s/alu_m/alu_a/alu_b
// to the ALU, alu_y/alu_co back. Option macro: MULDIV_EARLY_EXIT_EN.
module alu_muldiv_seq
    import alu_muldiv_seq_pkg::*;
#(
    parameter int         WIDTH   = MD_WIDTH,
    parameter logic [3:0] ADD_SEL = MD_ADD_SEL,
    parameter logic       ADD_M   = MD_ADD_M
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             res_dz,
    output logic [0:3]       alu_s,
    output logic             alu_m,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_co
);

    state_e           state;
    state_e           state_n;
    logic             op_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] opb_q;
    logic [4:0]       cnt;
    logic [WIDTH-1:0] st_a;
    logic [WIDTH-1:0] st_b;
    logic [WIDTH-1:0] st_hi;
    logic [WIDTH-1:0] st_lo;
    logic             early;
    logic             last;
    logic             fire_in;

    assign alu_s     = ADD_SEL;
    assign alu_m     = ADD_M;
    assign in_ready  = (state == S_IDLE);
    assign res_valid = (state == S_DONE);
    assign res_hi    = hi_q;
    assign res_lo    = lo_q;
    assign fire_in   = in_valid & in_ready;
    assign last      = (cnt == 5'(WIDTH-1));

    alu_muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op     (op_q),
        .hi     (hi_q),
        .lo     (lo_q),
        .opb    (opb_q),
        .alu_y  (alu_y),
        .alu_co (alu_co),
`ifdef MULDIV_EARLY_EXIT_EN
        .cnt    (cnt),
        .early  (early),
`endif
        .alu_a  (st_a),
        .alu_b  (st_b),
        .hi_n   (st_hi),
        .lo_n   (st_lo)
    );

`ifndef MULDIV_EARLY_EXIT_EN
    assign early = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        alu_a   = '0;
        alu_b   = '0;
        unique case (state)
            S_IDLE: begin
                if (fire_in) begin
                    if (in_op == OP_MUL) begin
                        state_n = S_ITER;
                    end else if (in_b == '0) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_PREP;
                    end
                end
            end
            S_PREP: begin
                // Two's-complement negation of the divisor via the adder.
                alu_a   = ~opb_q;
                alu_b   = {{(WIDTH-1){1'b0}}, 1'b1};
                state_n = S_ITER;
            end
            S_ITER: begin
                alu_a = st_a;
                alu_b = st_b;
                if (last || early) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            opb_q  <= '0;
            cnt    <= '0;
            res_dz <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (fire_in) begin
                        op_q   <= in_op;
                        cnt    <= '0;
                        hi_q   <= '0;
                        res_dz <= 1'b0;
                        if (in_op == OP_MUL) begin
                            lo_q  <= in_b;
                            opb_q <= in_a;
                        end else if (in_b == '0) begin
                            hi_q   <= in_a;
                            lo_q   <= '1;
                            opb_q  <= '0;
                            res_dz <= 1'b1;
                        end else begin
                            lo_q  <= in_a;
                            opb_q <= in_b;
                        end
                    end
                end
                S_PREP: begin
                    opb_q <= alu_y;
                end
                S_ITER: begin
                    hi_q <= st_hi;
                    lo_q <= st_lo;
                    cnt  <= cnt + 5'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
